// File: rtl/id_decode_stage.sv
// RV32I/RV64I decode stage: combinational decode of the incoming word into a
// registered 2-entry skid FIFO, so back-pressure never reaches in_ready combinationally.
module id_decode_stage #(
   parameter int XLEN  = 32,
   parameter int REG_W = 5,
   parameter int ALU_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [XLEN-1:0]  in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_pc,
   output logic [ALU_W-1:0] alu_type,
   output logic             imm_tag,
   output logic [XLEN-1:0]  extended_imm,
   output logic [REG_W-1:0] rd,
   output logic [REG_W-1:0] rs1,
   output logic [REG_W-1:0] rs2,
   output logic             rd_we,
   output logic             mem_read,
   output logic             mem_write,
   output logic             branch,
   output logic             jump,
   output logic             illegal
);

   localparam logic [ALU_W-1:0] A_NOP  = ALU_W'(0);
   localparam logic [ALU_W-1:0] A_ADD  = ALU_W'(1);
   localparam logic [ALU_W-1:0] A_SUB  = ALU_W'(2);
   localparam logic [ALU_W-1:0] A_SLL  = ALU_W'(3);
   localparam logic [ALU_W-1:0] A_SLT  = ALU_W'(4);
   localparam logic [ALU_W-1:0] A_SLTU = ALU_W'(5);
   localparam logic [ALU_W-1:0] A_XOR  = ALU_W'(6);
   localparam logic [ALU_W-1:0] A_SRL  = ALU_W'(7);
   localparam logic [ALU_W-1:0] A_SRA  = ALU_W'(8);
   localparam logic [ALU_W-1:0] A_OR   = ALU_W'(9);
   localparam logic [ALU_W-1:0] A_AND  = ALU_W'(10);

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   // Shift-immediate layout: shamt widens by one bit on RV64, shrinking the funct field.
   localparam int SH_W = (XLEN == 64) ? 6 : 5;
   localparam int FW   = 12 - SH_W;
   localparam logic [6:0]    SRA7    = 7'b0100000;
   localparam logic [FW-1:0] SRA_PAT = SRA7[6 -: FW];
   localparam bit            IS64    = (XLEN == 64);

   typedef struct packed {
      logic [XLEN-1:0]  pc;
      logic [ALU_W-1:0] alu;
      logic             imm_tag;
      logic [XLEN-1:0]  imm;
      logic [REG_W-1:0] rd;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic             rd_we;
      logic             mem_read;
      logic             mem_write;
      logic             branch;
      logic             jump;
      logic             illegal;
   } entry_t;

   logic [6:0]      opcode;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic [FW-1:0]   sh_hi;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
   logic            bad;
   entry_t          dec;

   assign opcode = in_inst[6:0];
   assign f3     = in_inst[14:12];
   assign f7     = in_inst[31:25];
   assign sh_hi  = in_inst[31 -: FW];

   assign imm_i  = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
   assign imm_s  = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
   assign imm_b  = {{(XLEN-13){in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                    in_inst[11:8], 1'b0};
   assign imm_u  = {{(XLEN-32){in_inst[31]}}, in_inst[31:12], 12'b0};
   assign imm_j  = {{(XLEN-21){in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                    in_inst[30:21], 1'b0};
   assign imm_sh = {{(XLEN-SH_W){1'b0}}, in_inst[20 +: SH_W]};

   always_comb begin
      dec    = '0;
      bad    = 1'b0;
      dec.pc = in_pc;
      unique case (opcode)
         OP_R: begin
            dec.rd    = REG_W'(in_inst[11:7]);
            dec.rs1   = REG_W'(in_inst[19:15]);
            dec.rs2   = REG_W'(in_inst[24:20]);
            dec.rd_we = 1'b1;
            case ({f7, f3})
               {7'b0000000, 3'b000}: dec.alu = A_ADD;
               {7'b0100000, 3'b000}: dec.alu = A_SUB;
               {7'b0000000, 3'b001}: dec.alu = A_SLL;
               {7'b0000000, 3'b010}: dec.alu = A_SLT;
               {7'b0000000, 3'b011}: dec.alu = A_SLTU;
               {7'b0000000, 3'b100}: dec.alu = A_XOR;
               {7'b0000000, 3'b101}: dec.alu = A_SRL;
               {7'b0100000, 3'b101}: dec.alu = A_SRA;
               {7'b0000000, 3'b110}: dec.alu = A_OR;
               {7'b0000000, 3'b111}: dec.alu = A_AND;
               default:              bad     = 1'b1;
            endcase
         end
         OP_I: begin
            dec.rd      = REG_W'(in_inst[11:7]);
            dec.rs1     = REG_W'(in_inst[19:15]);
            dec.rd_we   = 1'b1;
            dec.imm_tag = 1'b1;
            dec.imm     = imm_i;
            case (f3)
               3'b000: dec.alu = A_ADD;
               3'b010: dec.alu = A_SLT;
               3'b011: dec.alu = A_SLTU;
               3'b100: dec.alu = A_XOR;
               3'b110: dec.alu = A_OR;
               3'b111: dec.alu = A_AND;
               3'b001: begin
                  dec.alu = A_SLL;
                  dec.imm = imm_sh;
                  bad     = (sh_hi != '0);
               end
               default: begin
                  dec.imm = imm_sh;
                  if (sh_hi == '0)          dec.alu = A_SRL;
                  else if (sh_hi == SRA_PAT) dec.alu = A_SRA;
                  else                       bad     = 1'b1;
               end
            endcase
         end
         OP_LOAD: begin
            dec.alu      = A_ADD;
            dec.rd       = REG_W'(in_inst[11:7]);
            dec.rs1      = REG_W'(in_inst[19:15]);
            dec.imm_tag  = 1'b1;
            dec.imm      = imm_i;
            dec.rd_we    = 1'b1;
            dec.mem_read = 1'b1;
            // lb/lh/lw/lbu/lhu always; ld/lwu only on RV64
            bad = (f3 == 3'b111) || (!IS64 && (f3 == 3'b011 || f3 == 3'b110));
         end
         OP_STORE: begin
            dec.alu       = A_ADD;
            dec.rs1       = REG_W'(in_inst[19:15]);
            dec.rs2       = REG_W'(in_inst[24:20]);
            dec.imm_tag   = 1'b1;
            dec.imm       = imm_s;
            dec.mem_write = 1'b1;
            bad = f3[2] || (!IS64 && f3 == 3'b011);
         end
         OP_BR: begin
            dec.alu    = A_SUB;
            dec.rs1    = REG_W'(in_inst[19:15]);
            dec.rs2    = REG_W'(in_inst[24:20]);
            dec.imm    = imm_b;
            dec.branch = 1'b1;
            bad = (f3 == 3'b010) || (f3 == 3'b011);
         end
         OP_LUI, OP_AUIPC: begin
            dec.alu     = A_ADD;
            dec.rd      = REG_W'(in_inst[11:7]);
            dec.imm_tag = 1'b1;
            dec.imm     = imm_u;
            dec.rd_we   = 1'b1;
         end
         OP_JAL: begin
            dec.alu     = A_ADD;
            dec.rd      = REG_W'(in_inst[11:7]);
            dec.imm_tag = 1'b1;
            dec.imm     = imm_j;
            dec.rd_we   = 1'b1;
            dec.jump    = 1'b1;
         end
         OP_JALR: begin
            dec.alu     = A_ADD;
            dec.rd      = REG_W'(in_inst[11:7]);
            dec.rs1     = REG_W'(in_inst[19:15]);
            dec.imm_tag = 1'b1;
            dec.imm     = imm_i;
            dec.rd_we   = 1'b1;
            dec.jump    = 1'b1;
            bad = (f3 != 3'b000);
         end
         default: bad = 1'b1;
      endcase
      // Illegal words still carry their PC so the trap logic downstream knows where.
      if (bad) begin
         dec         = '0;
         dec.pc      = in_pc;
         dec.illegal = 1'b1;
      end
   end

   entry_t     mem [2];
   logic       head, tail;
   logic [1:0] count;
   logic       push, pop;
   entry_t     head_e;

   assign in_ready  = !rst && (count < 2'd2);
   assign out_valid = (count != 2'd0);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count  <= 2'd0;
         head   <= 1'b0;
         tail   <= 1'b0;
         mem[0] <= '0;
         mem[1] <= '0;
      end else if (flush) begin
         count <= 2'd0;
         head  <= 1'b0;
         tail  <= 1'b0;
      end else begin
         if (push) begin
            mem[tail] <= dec;
            tail      <= ~tail;
         end
         if (pop) head <= ~head;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   // Outputs read zero whenever the buffer is empty so stale entries never leak.
   assign head_e = out_valid ? mem[head] : '0;

   assign out_pc       = head_e.pc;
   assign alu_type     = head_e.alu;
   assign imm_tag      = head_e.imm_tag;
   assign extended_imm = head_e.imm;
   assign rd           = head_e.rd;
   assign rs1          = head_e.rs1;
   assign rs2          = head_e.rs2;
   assign rd_we        = head_e.rd_we;
   assign mem_read     = head_e.mem_read;
   assign mem_write    = head_e.mem_write;
   assign branch       = head_e.branch;
   assign jump         = head_e.jump;
   assign illegal      = head_e.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// Scoreboard bench for id_decode_stage: stimulus queues hand-decoded expectations,
// a negedge monitor pops and compares on every output transfer.
module tb_id_decode_stage;

   logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_inst, in_pc, out_pc, extended_imm;
   logic [3:0]  alu_type;
   logic        imm_tag, rd_we, mem_read, mem_write, branch, jump, illegal;
   logic [4:0]  rd, rs1, rs2;

   typedef struct packed {
      logic [31:0] pc;
      logic [3:0]  alu;
      logic        it;
      logic [31:0] imm;
      logic [4:0]  rd, rs1, rs2;
      logic        we, mr, mw, br, j, ill;
   } ent_t;

   ent_t q[$];
   int   n_chk = 0;
   int   n_fail = 0;

   id_decode_stage #(.XLEN(32), .REG_W(5), .ALU_W(4)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .alu_type(alu_type), .imm_tag(imm_tag), .extended_imm(extended_imm),
      .rd(rd), .rs1(rs1), .rs2(rs2), .rd_we(rd_we), .mem_read(mem_read),
      .mem_write(mem_write), .branch(branch), .jump(jump), .illegal(illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic ent_t mk(input logic [3:0] alu, input logic it, input logic [31:0] imm,
                               input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                               input logic [5:0] fl);
      ent_t e;
      e.pc  = '0;
      e.alu = alu;  e.it = it;  e.imm = imm;
      e.rd  = d;    e.rs1 = s1; e.rs2 = s2;
      {e.we, e.mr, e.mw, e.br, e.j, e.ill} = fl;
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // Monitor: a transfer happens at the next posedge when out_valid & out_ready at negedge.
   always @(negedge clk) begin
      ent_t g, e;
      if (rst || flush) q.delete();
      else if (out_valid && out_ready) begin
         g = '{out_pc, alu_type, imm_tag, extended_imm, rd, rs1, rs2,
               rd_we, mem_read, mem_write, branch, jump, illegal};
         n_chk++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_out got pc=%h bundle=%h exp=none", out_pc, g);
         end else begin
            e = q.pop_front();
            if (g !== e) begin
               n_fail++;
               $display("FAIL out_bundle pc=%h got=%h exp=%h", e.pc, g, e);
            end
         end
      end
   end

   // Offer one instruction and hold it until accepted; expectation is queued on accept.
   task automatic send(input logic [31:0] inst, input logic [31:0] pc, input ent_t e);
      bit done = 0;
      in_valid = 1'b1; in_inst = inst; in_pc = pc;
      e.pc = pc;
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge clk);
         if (in_ready) begin
            q.push_back(e);
            done = 1;
         end
         @(posedge clk); #1;
      end
      if (!done) chk("send_timeout", 64'(pc), 64'hFFFF_FFFF);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   logic [31:0] vi [11];
   ent_t        ve [11];

   initial begin
      //              alu it imm           rd  rs1 rs2 {we,mr,mw,br,j,ill}
      vi[0]  = 32'hFFF00093; ve[0]  = mk(1,  1, 32'hFFFFFFFF, 1, 0, 0, 6'b100000); // addi x1,x0,-1
      vi[1]  = 32'h402081B3; ve[1]  = mk(2,  0, 32'h0,        3, 1, 2, 6'b100000); // sub x3,x1,x2
      vi[2]  = 32'h0020A423; ve[2]  = mk(1,  1, 32'h8,        0, 1, 2, 6'b001000); // sw x2,8(x1)
      vi[3]  = 32'hFFC12283; ve[3]  = mk(1,  1, 32'hFFFFFFFC, 5, 2, 0, 6'b110000); // lw x5,-4(x2)
      vi[4]  = 32'hFE208CE3; ve[4]  = mk(2,  0, 32'hFFFFFFF8, 0, 1, 2, 6'b000100); // beq x1,x2,-8
      vi[5]  = 32'h123453B7; ve[5]  = mk(1,  1, 32'h12345000, 7, 0, 0, 6'b100000); // lui x7,0x12345
      vi[6]  = 32'h010000EF; ve[6]  = mk(1,  1, 32'h10,       1, 0, 0, 6'b100010); // jal x1,+16
      vi[7]  = 32'h4051D213; ve[7]  = mk(8,  1, 32'h5,        4, 3, 0, 6'b100000); // srai x4,x3,5
      vi[8]  = 32'h02009093; ve[8]  = mk(0,  0, 32'h0,        0, 0, 0, 6'b000001); // slli bad funct7
      vi[9]  = 32'hFFFFFFFF; ve[9]  = mk(0,  0, 32'h0,        0, 0, 0, 6'b000001); // bad opcode
      vi[10] = 32'h0083F333; ve[10] = mk(10, 0, 32'h0,        6, 7, 8, 6'b100000); // and x6,x7,x8

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_inst = '0; in_pc = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 0);
      chk("rst_in_ready", 64'(in_ready), 0);
      chk("rst_alu_imm", {alu_type, extended_imm}, 0);
      rst = 1'b0;
      #1;
      chk("in_ready_after_rst", 64'(in_ready), 1);

      // First-instruction latency: visible right after the accepting edge.
      out_ready = 1'b1;
      send(vi[0], 32'h1000, ve[0]);
      chk("lat_out_valid", 64'(out_valid), 1);
      chk("lat_imm", 64'(extended_imm), 64'hFFFFFFFF);
      for (int i = 1; i < 11; i++) send(vi[i], 32'h1000 + 32'(4 * i), ve[i]);
      idle(3);

      // Back-pressure: third offer must be refused while two are buffered.
      out_ready = 1'b0;
      send(vi[1], 32'h2000, ve[1]);
      send(vi[2], 32'h2004, ve[2]);
      in_valid = 1'b1; in_inst = vi[3]; in_pc = 32'h2008;
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 0);
      chk("bp_head_pc", 64'(out_pc), 64'h2000);
      @(posedge clk); #1;
      chk("bp_hold_pc", 64'(out_pc), 64'h2000);
      out_ready = 1'b1;
      send(vi[3], 32'h2008, ve[3]);
      idle(4);

      // Streaming at count=1: push and pop every cycle.
      for (int i = 0; i < 11; i++) begin
         send(vi[i], 32'h3000 + 32'(4 * i), ve[i]);
         chk("stream_out_valid", 64'(out_valid), 1);
         chk("stream_in_ready", 64'(in_ready), 1);
      end
      idle(3);

      // Flush with two buffered and a new offer; none of them may appear.
      out_ready = 1'b0;
      send(vi[5], 32'h4000, ve[5]);
      send(vi[6], 32'h4004, ve[6]);
      in_valid = 1'b1; in_inst = vi[7]; in_pc = 32'h4008; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_out_valid", 64'(out_valid), 0);
      chk("flush_in_ready", 64'(in_ready), 1);
      out_ready = 1'b1;
      send(vi[10], 32'h400C, ve[10]);
      idle(3);

      // Async reset with two entries queued.
      out_ready = 1'b0;
      send(vi[1], 32'h5000, ve[1]);
      send(vi[2], 32'h5004, ve[2]);
      chk("pre_rst_out_valid", 64'(out_valid), 1);
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 0);
      chk("midrst_fields", {alu_type, rd, rs1, rs2, mem_write}, 0);
      chk("midrst_in_ready", 64'(in_ready), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      send(vi[4], 32'h6000, ve[4]);

      for (int k = 0; k < 20 && q.size() != 0; k++) begin @(posedge clk); #1; end
      chk("scoreboard_drained", 64'(q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
